// File: rtl/syncounter_arbiter.sv
// Round-robin arbiter sharing one up/down counter between two single-step requesters.
// Issues one strobe per grant, refuses steps that would wrap and flags a counter that fails to move.
module syncounter_arbiter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req0_dir,
  output logic             req0_ready,
  output logic             req0_err,
  input  logic             req1_valid,
  input  logic             req1_dir,
  output logic             req1_ready,
  output logic             req1_err,
  input  logic [WIDTH-1:0] count,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             grant_id,
  output logic             fault
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state, state_nxt;
  logic             dir, dir_nxt;
  logic             err, err_nxt;
  logic             ptr, ptr_nxt;
  logic             id_nxt;
  logic             fault_nxt;
  logic [WIDTH-1:0] exp_q, exp_nxt;
  logic [HW-1:0]    hold, hold_nxt;
  logic             sel, sdir, refuse;

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    err_nxt   = err;
    ptr_nxt   = ptr;
    id_nxt    = grant_id;
    fault_nxt = fault;
    exp_nxt   = exp_q;
    hold_nxt  = hold;
    sel       = 1'b0;
    sdir      = 1'b0;
    refuse    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // pointer only decides a contested grant; a lone requester always wins
          sel       = (req0_valid && req1_valid) ? ptr : req1_valid;
          sdir      = sel ? req1_dir : req0_dir;
          refuse    = sdir ? (count == MAXV) : (count == '0);
          id_nxt    = sel;
          dir_nxt   = sdir;
          ptr_nxt   = ~sel;
          exp_nxt   = sdir ? count + 1'b1 : count - 1'b1;
          err_nxt   = refuse;
          state_nxt = refuse ? ACK : ISSUE;
        end
      end
      ISSUE: begin
        hold_nxt  = HW'(HOLD_CYC - 1);
        state_nxt = WAIT;
      end
      WAIT: begin
        if (hold == '0) begin
          if (count != exp_q) fault_nxt = 1'b1;
          state_nxt = ACK;
        end else begin
          hold_nxt = hold - 1'b1;
        end
      end
      ACK: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      err        <= 1'b0;
      ptr        <= 1'b0;
      exp_q      <= '0;
      hold       <= '0;
      grant_id   <= 1'b0;
      fault      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      busy       <= 1'b0;
      req0_ready <= 1'b0;
      req0_err   <= 1'b0;
      req1_ready <= 1'b0;
      req1_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      err        <= err_nxt;
      ptr        <= ptr_nxt;
      exp_q      <= exp_nxt;
      hold       <= hold_nxt;
      grant_id   <= id_nxt;
      fault      <= fault_nxt;
      up         <= (state_nxt == ISSUE) && dir_nxt;
      down       <= (state_nxt == ISSUE) && !dir_nxt;
      busy       <= (state_nxt != IDLE);
      req0_ready <= (state_nxt == ACK) && !id_nxt;
      req0_err   <= (state_nxt == ACK) && !id_nxt && err_nxt;
      req1_ready <= (state_nxt == ACK) && id_nxt;
      req1_err   <= (state_nxt == ACK) && id_nxt && err_nxt;
    end
  end

endmodule

// File: tb/tb_syncounter_arbiter.sv
// Directed bench for syncounter_arbiter with a behavioural up/down counter attached.
module tb_syncounter_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       r0v = 1'b0, r0d = 1'b0, r1v = 1'b0, r1d = 1'b0;
  logic       r0rdy, r0err, r1rdy, r1err;
  logic [3:0] count = 4'd0;
  logic       up, down, busy, grant_id, fault;

  logic       ignore = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ldv = 4'd0;

  int total = 0;
  int bad = 0;

  syncounter_arbiter #(.WIDTH(4), .HOLD_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_dir(r0d), .req0_ready(r0rdy), .req0_err(r0err),
    .req1_valid(r1v), .req1_dir(r1d), .req1_ready(r1rdy), .req1_err(r1err),
    .count(count), .up(up), .down(down), .busy(busy),
    .grant_id(grant_id), .fault(fault)
  );

  always #5 clk = ~clk;

  // counter model: load has priority, ignore models a stuck counter
  always @(posedge clk) begin
    if (ld) count <= ldv;
    else if (!ignore) begin
      if (up) count <= count + 4'd1;
      else if (down) count <= count - 4'd1;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst) chk1("up_down_excl", up & down, 1'b0);

  task automatic chk_idle_outs(input string tag);
    chk1({tag, "_up"}, up, 1'b0);
    chk1({tag, "_down"}, down, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_r0rdy"}, r0rdy, 1'b0);
    chk1({tag, "_r1rdy"}, r1rdy, 1'b0);
    chk1({tag, "_r0err"}, r0err, 1'b0);
    chk1({tag, "_r1err"}, r1err, 1'b0);
  endtask

  task automatic set_count(input logic [3:0] v);
    @(negedge clk);
    ld = 1'b1;
    ldv = v;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic drop(input logic who);
    if (who) r1v = 1'b0; else r0v = 1'b0;
  endtask

  // Called at a negedge; that cycle is cycle 0 of the request.
  task automatic do_step(input logic who, input logic d, input logic e, input logic [3:0] after);
    if (who) begin r1v = 1'b1; r1d = d; end else begin r0v = 1'b1; r0d = d; end
    @(negedge clk);
    if (e) begin
      chk1("ref_up", up, 1'b0);
      chk1("ref_down", down, 1'b0);
      chk1("ref_ready", who ? r1rdy : r0rdy, 1'b1);
      chk1("ref_err", who ? r1err : r0err, 1'b1);
      chk1("ref_other_rdy", who ? r0rdy : r1rdy, 1'b0);
      chk1("ref_gid", grant_id, who);
      chk1("ref_busy", busy, 1'b1);
      drop(who);
      @(negedge clk);
      chk4("ref_count", count, after);
      chk_idle_outs("ref_after");
    end else begin
      chk1("c1_up", up, d);
      chk1("c1_down", down, !d);
      chk1("c1_busy", busy, 1'b1);
      chk1("c1_gid", grant_id, who);
      chk1("c1_ready", who ? r1rdy : r0rdy, 1'b0);
      @(negedge clk);
      chk1("c2_up", up, 1'b0);
      chk1("c2_down", down, 1'b0);
      chk4("c2_count", count, after);
      chk1("c2_busy", busy, 1'b1);
      @(negedge clk);
      chk1("c3_ready", who ? r1rdy : r0rdy, 1'b1);
      chk1("c3_err", who ? r1err : r0err, 1'b0);
      chk1("c3_other_rdy", who ? r0rdy : r1rdy, 1'b0);
      chk1("c3_busy", busy, 1'b1);
      drop(who);
      @(negedge clk);
      chk_idle_outs("c4");
    end
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic       who;
    logic       d;
    logic       e;
    logic [3:0] after;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{4'd5,  1'b0, 1'b1, 1'b0, 4'd6};
    tbl[1] = '{4'd15, 1'b1, 1'b1, 1'b1, 4'd15};
    tbl[2] = '{4'd0,  1'b0, 1'b0, 1'b1, 4'd0};
    tbl[3] = '{4'd0,  1'b1, 1'b1, 1'b0, 4'd1};
    tbl[4] = '{4'd15, 1'b0, 1'b0, 1'b0, 4'd14};
    tbl[5] = '{4'd8,  1'b1, 1'b0, 1'b0, 4'd7};
    tbl[6] = '{4'd14, 1'b0, 1'b1, 1'b0, 4'd15};
    tbl[7] = '{4'd1,  1'b1, 1'b0, 1'b0, 4'd0};

    // power-on reset
    #1;
    chk_idle_outs("por");
    chk1("por_gid", grant_id, 1'b0);
    chk1("por_fault", fault, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // single-step table
    for (int unsigned i = 0; i < 8; i++) begin
      set_count(tbl[i].cnt);
      do_step(tbl[i].who, tbl[i].d, tbl[i].e, tbl[i].after);
    end

    // both requesters at once: req0 first, then req1
    set_count(4'd7);
    r0v = 1'b1; r0d = 1'b1; r1v = 1'b1; r1d = 1'b0;
    @(negedge clk);
    chk1("rr_c1_up", up, 1'b1);
    chk1("rr_c1_gid", grant_id, 1'b0);
    @(negedge clk);
    chk4("rr_c2_count", count, 4'd8);
    @(negedge clk);
    chk1("rr_c3_r0rdy", r0rdy, 1'b1);
    chk1("rr_c3_r1rdy", r1rdy, 1'b0);
    r0v = 1'b0;
    @(negedge clk);
    chk1("rr_c4_busy", busy, 1'b0);
    @(negedge clk);
    chk1("rr_c5_down", down, 1'b1);
    chk1("rr_c5_up", up, 1'b0);
    chk1("rr_c5_gid", grant_id, 1'b1);
    @(negedge clk);
    chk4("rr_c6_count", count, 4'd7);
    @(negedge clk);
    chk1("rr_c7_r1rdy", r1rdy, 1'b1);
    chk1("rr_c7_r0rdy", r0rdy, 1'b0);
    chk1("rr_c7_r1err", r1err, 1'b0);
    r1v = 1'b0;
    @(negedge clk);
    chk_idle_outs("rr_c8");

    // stuck counter raises sticky fault
    ignore = 1'b1;
    set_count(4'd9);
    r0v = 1'b1; r0d = 1'b1;
    @(negedge clk);
    chk1("flt_c1_up", up, 1'b1);
    @(negedge clk);
    chk4("flt_c2_count", count, 4'd9);
    chk1("flt_c2_fault", fault, 1'b0);
    @(negedge clk);
    chk1("flt_c3_fault", fault, 1'b1);
    chk1("flt_c3_ready", r0rdy, 1'b1);
    r0v = 1'b0;
    ignore = 1'b0;
    @(negedge clk);
    do_step(1'b0, 1'b1, 1'b0, 4'd10);
    chk1("flt_sticky1", fault, 1'b1);
    do_step(1'b1, 1'b0, 1'b0, 4'd9);
    chk1("flt_sticky2", fault, 1'b1);

    // mid-sim reset clears everything; idle afterwards with count=0
    set_count(4'd0);
    rst = 1'b0;
    #1;
    chk_idle_outs("rst");
    chk1("rst_fault", fault, 1'b0);
    chk1("rst_gid", grant_id, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk1("rst_idle_busy", busy, 1'b0);
    end

    // reset during ISSUE drops the strobe and the request; re-granted afterwards
    set_count(4'd3);
    r0v = 1'b1; r0d = 1'b1;
    @(posedge clk);
    #2;
    chk1("rmid_up_before", up, 1'b1);
    rst = 1'b0;
    #1;
    chk1("rmid_up", up, 1'b0);
    chk1("rmid_busy", busy, 1'b0);
    chk1("rmid_ready", r0rdy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk4("rmid_count", count, 4'd3);
    chk1("rmid_ready2", r0rdy, 1'b0);
    rst = 1'b1;
    do_step(1'b0, 1'b1, 1'b0, 4'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
